// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing constants, receiver FSM encoding and
// GRB byte-slice positions. The transmitter and receiver both use it.
// All cycle counts are derived from CLK_HZ_DEF (50 MHz -> 20 ns/cycle).
package ws2812_pkg;

  localparam int unsigned CLK_HZ_DEF     = 50_000_000;

  // Nominal transmit high times.
  localparam int unsigned T0H_CYC        = CLK_HZ_DEF / 2_500_000;       // 400 ns -> 20
  localparam int unsigned T1H_CYC        = CLK_HZ_DEF / 1_250_000;       // 800 ns -> 40

  // Receive classification thresholds.
  localparam int unsigned T_MIN_HIGH_DEF = CLK_HZ_DEF / 10_000_000;      // 100 ns -> 5
  localparam int unsigned T_THRESH_DEF   = (T0H_CYC + T1H_CYC) / 2;      // 600 ns -> 30
  localparam int unsigned T_MAX_HIGH_DEF = CLK_HZ_DEF / 10_000_000 * 12; // 1.2 us -> 60
  localparam int unsigned T_RESET_DEF    = CLK_HZ_DEF / 20_000;          // 50 us  -> 2500

  localparam int unsigned IDX_W_DEF      = 8;
  localparam int unsigned PIX_BITS       = 24;

  // GRB order on the wire: green first (MSB), blue last.
  localparam int unsigned G_MSB = 23;
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_decoder_if.sv
// ws2812_rx_decoder_if: decoded pixel/frame output bundle of the receiver.
//   pix_valid/pix_r/pix_g/pix_b/pix_idx : one-cycle pixel strobe + held data
//   frame_done/frame_pix_cnt            : frame-end strobe + held pixel count
//   bit_err                             : error strobe
//   busy                                : frame in progress
// master = decoder (drives), slave = consumer.
interface ws2812_rx_decoder_if
  import ws2812_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
);
  logic             pix_valid;
  logic [7:0]       pix_r;
  logic [7:0]       pix_g;
  logic [7:0]       pix_b;
  logic [IDX_W-1:0] pix_idx;
  logic             frame_done;
  logic [IDX_W-1:0] frame_pix_cnt;
  logic             bit_err;
  logic             busy;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b, pix_idx,
           frame_done, frame_pix_cnt, bit_err, busy
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b, pix_idx,
           frame_done, frame_pix_cnt, bit_err, busy
  );
endinterface

// File: rtl/ws2812_din_sync.sv
// ws2812_din_sync: 2-FF synchronizer for the asynchronous data line plus
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized din (2 cycles latency)
//   rise, fall : one-cycle pulses on level transitions
module ws2812_din_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;
endmodule

// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder: WS2812 NRZ receiver. Measures high/low widths of the
// synchronized data line, decodes bits MSB first into 24-bit GRB pixels and
// reports frame boundaries at the latch/reset gap.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   din                : asynchronous WS2812 data line
//   pix                : decoded outputs (ws2812_rx_decoder_if.master)
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEF,
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
  parameter int unsigned T_RESET    = T_RESET_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                din,
  ws2812_rx_decoder_if.master pix
);
  localparam int unsigned CNT_W = $clog2(T_RESET + 1);

  localparam logic [CNT_W-1:0] MIN_HIGH_W  = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0] THRESH_W    = CNT_W'(T_THRESH);
  // "Reaching" a limit is detected one count early so cnt never exceeds it.
  localparam logic [CNT_W-1:0] MAX_HIGH_LST = CNT_W'(T_MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] RESET_LST    = CNT_W'(T_RESET - 1);
  localparam logic [4:0]       LAST_BIT     = 5'(PIX_BITS - 1);

  logic s_level, s_rise, s_fall;

  ws2812_din_sync u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .din   (din),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  rx_state_e            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [4:0]           bit_cnt, bit_cnt_d;
  logic [PIX_BITS-1:0]  sr, sr_d, sr_next;
  logic [IDX_W-1:0]     run_idx, run_idx_d;
  logic [7:0]           pix_r_q, pix_r_d;
  logic [7:0]           pix_g_q, pix_g_d;
  logic [7:0]           pix_b_q, pix_b_d;
  logic [IDX_W-1:0]     pix_idx_q, pix_idx_d;
  logic [IDX_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bit_err_q, bit_err_d;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= S_SYNC;
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      run_idx      <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      pix_idx_q    <= '0;
      frame_cnt_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      bit_err_q    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bit_cnt      <= bit_cnt_d;
      sr           <= sr_d;
      run_idx      <= run_idx_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      pix_idx_q    <= pix_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      bit_err_q    <= bit_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_cnt_d    = bit_cnt;
    sr_d         = sr;
    sr_next      = {sr[PIX_BITS-2:0], (cnt >= THRESH_W)};
    run_idx_d    = run_idx;
    pix_r_d      = pix_r_q;
    pix_g_d      = pix_g_q;
    pix_b_d      = pix_b_q;
    pix_idx_d    = pix_idx_q;
    frame_cnt_d  = frame_cnt_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    bit_err_d    = 1'b0;

    case (state)
      S_SYNC: begin
        if (s_level) begin
          cnt_d = '0;
        end else if (cnt == RESET_LST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_IDLE: begin
        if (s_rise) begin
          cnt_d     = CNT_W'(1);
          bit_cnt_d = '0;
          run_idx_d = '0;
          pix_idx_d = '0;
          state_d   = S_HIGH;
        end
      end

      S_HIGH: begin
        // A fall takes priority, so a width of T_MAX_HIGH-1 still decodes.
        if (s_fall) begin
          if (cnt < MIN_HIGH_W) begin
            bit_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_SYNC;
          end else begin
            sr_d    = sr_next;
            cnt_d   = CNT_W'(1);
            state_d = S_LOW;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_d   = '0;
              pix_g_d     = sr_next[G_MSB:G_LSB];
              pix_r_d     = sr_next[R_MSB:R_LSB];
              pix_b_d     = sr_next[B_MSB:B_LSB];
              pix_idx_d   = run_idx;
              run_idx_d   = run_idx + 1'b1;
              pix_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end else if (cnt == MAX_HIGH_LST) begin
          bit_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_SYNC;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_LOW: begin
        if (s_rise) begin
          cnt_d   = CNT_W'(1);
          state_d = S_HIGH;
        end else if (cnt == RESET_LST) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = run_idx;
          bit_err_d    = (bit_cnt != '0);
          bit_cnt_d    = '0;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_SYNC;
      end
    endcase
  end

  assign pix.pix_valid     = pix_valid_q;
  assign pix.pix_r         = pix_r_q;
  assign pix.pix_g         = pix_g_q;
  assign pix.pix_b         = pix_b_q;
  assign pix.pix_idx       = pix_idx_q;
  assign pix.frame_done    = frame_done_q;
  assign pix.frame_pix_cnt = frame_cnt_q;
  assign pix.bit_err       = bit_err_q;
  assign pix.busy          = (state == S_HIGH) || (state == S_LOW);
endmodule

// File: tb/tb_ws2812_rx_decoder.sv
`timescale 1ns/1ps
module tb_ws2812_rx_decoder;
  import ws2812_pkg::*;

  localparam int unsigned HALF_NS = 1_000_000_000 / CLK_HZ_DEF / 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic din       = 1'b0;

  always #(HALF_NS) sys_clk = ~sys_clk;

  ws2812_rx_decoder_if #(.IDX_W(8)) pix_if ();

  ws2812_rx_decoder #(
    .T_MIN_HIGH (5),
    .T_THRESH   (30),
    .T_MAX_HIGH (60),
    .T_RESET    (2500),
    .IDX_W      (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .pix       (pix_if)
  );

  typedef struct {
    logic [23:0] grb;
    logic [7:0]  g;
    logic [7:0]  r;
    logic [7:0]  b;
    logic [7:0]  idx;
    bit          last;
    logic [7:0]  fcnt;
  } vec_t;

  typedef struct {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] idx;
  } pix_exp_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
  } frm_exp_t;

  vec_t     vecs [6];
  pix_exp_t pix_q [$];
  frm_exp_t frm_q [$];

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int err_seen = 0;
  int pix_pushed = 0;
  int pix_seen = 0;
  int frm_pushed = 0;
  int frm_seen = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1 ns after a rising edge.
  task automatic send_level(input logic v, input int unsigned n);
    din = v;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit_w(input int unsigned h, input int unsigned l);
    send_level(1'b1, h);
    send_level(1'b0, l);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_bit_w(40, 22);
    else   send_bit_w(20, 42);
  endtask

  task automatic send_pixel(input logic [23:0] grb);
    for (int i = 23; i >= 0; i--) send_bit(grb[i]);
  endtask

  task automatic push_pix(input logic [7:0] g, input logic [7:0] r,
                          input logic [7:0] b, input logic [7:0] idx);
    pix_exp_t e;
    e.g = g; e.r = r; e.b = b; e.idx = idx;
    pix_q.push_back(e);
    pix_pushed++;
  endtask

  task automatic push_frm(input logic [7:0] cnt, input logic err);
    frm_exp_t e;
    e.cnt = cnt; e.err = err;
    frm_q.push_back(e);
    frm_pushed++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"},  {31'd0, pix_if.pix_valid}, 32'd0);
    check({tag, "_grb"},        {8'd0, pix_if.pix_g, pix_if.pix_r, pix_if.pix_b}, 32'd0);
    check({tag, "_idx_fcnt"},   {16'd0, pix_if.pix_idx, pix_if.frame_pix_cnt}, 32'd0);
    check({tag, "_strobes"},    {29'd0, pix_if.frame_done, pix_if.bit_err, pix_if.busy}, 32'd0);
  endtask

  initial begin
    logic [23:0] wgrb;
    logic [23:0] rgrb;
    int          err_at;

    vecs[0] = '{grb: 24'hA53CF0, g: 8'hA5, r: 8'h3C, b: 8'hF0, idx: 8'd0, last: 1'b1, fcnt: 8'd1};
    vecs[1] = '{grb: 24'h00FF00, g: 8'h00, r: 8'hFF, b: 8'h00, idx: 8'd0, last: 1'b0, fcnt: 8'd0};
    vecs[2] = '{grb: 24'hFFFFFF, g: 8'hFF, r: 8'hFF, b: 8'hFF, idx: 8'd1, last: 1'b0, fcnt: 8'd0};
    vecs[3] = '{grb: 24'h000001, g: 8'h00, r: 8'h00, b: 8'h01, idx: 8'd2, last: 1'b1, fcnt: 8'd3};
    vecs[4] = '{grb: 24'h123456, g: 8'h12, r: 8'h34, b: 8'h56, idx: 8'd0, last: 1'b0, fcnt: 8'd0};
    vecs[5] = '{grb: 24'h89ABCD, g: 8'h89, r: 8'hAB, b: 8'hCD, idx: 8'd1, last: 1'b1, fcnt: 8'd2};

    fork
      begin : monitor
        pix_exp_t pe;
        frm_exp_t fe;
        while (!done) begin
          @(negedge sys_clk);
          if (pix_if.pix_valid === 1'b1) begin
            pix_seen++;
            if (pix_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL pix_unexpected actual=strobe grb=%0h required=no strobe",
                       {pix_if.pix_g, pix_if.pix_r, pix_if.pix_b});
            end else begin
              pe = pix_q.pop_front();
              check("pix_grb", {8'd0, pix_if.pix_g, pix_if.pix_r, pix_if.pix_b},
                    {8'd0, pe.g, pe.r, pe.b});
              check("pix_idx", {24'd0, pix_if.pix_idx}, {24'd0, pe.idx});
            end
          end
          if (pix_if.frame_done === 1'b1) begin
            frm_seen++;
            if (frm_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_unexpected actual=strobe cnt=%0d required=no strobe",
                       pix_if.frame_pix_cnt);
            end else begin
              fe = frm_q.pop_front();
              check("frame_pix_cnt", {24'd0, pix_if.frame_pix_cnt}, {24'd0, fe.cnt});
              check("frame_bit_err", {31'd0, pix_if.bit_err}, {31'd0, fe.err});
            end
          end
          if (pix_if.bit_err === 1'b1) err_seen++;
        end
      end

      begin : stimulus
        // Reset state, then a sync gap.
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        send_level(1'b0, 2600);

        // Table of nominal pixels and frames.
        for (int i = 0; i < 6; i++) begin
          push_pix(vecs[i].g, vecs[i].r, vecs[i].b, vecs[i].idx);
          send_pixel(vecs[i].grb);
          if (vecs[i].last) begin
            push_frm(vecs[i].fcnt, 1'b0);
            send_level(1'b0, 2600);
          end
        end

        // Width boundaries: '1' as 30/59 high, '0' as 29/5 high.
        wgrb = 24'hC35A81;
        push_pix(8'hC3, 8'h5A, 8'h81, 8'd0);
        for (int i = 23; i >= 0; i--) begin
          if (wgrb[i]) send_bit_w((i % 2 == 0) ? 30 : 59, 22);
          else         send_bit_w((i % 2 == 0) ? 29 : 5, 42);
        end
        push_frm(8'd1, 1'b0);
        send_level(1'b0, 2600);

        // Glitch: 4-cycle high aborts; next pixel ignored until a gap.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        exp_err++;
        send_bit_w(4, 42);
        send_pixel(24'hFFFFFF);
        send_level(1'b0, 2600);
        push_pix(8'h5A, 8'h5A, 8'h5A, 8'd0);
        send_pixel(24'h5A5A5A);
        push_frm(8'd1, 1'b0);
        send_level(1'b0, 2600);

        // Partial pixel at frame end.
        push_frm(8'd0, 1'b1);
        exp_err++;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        send_level(1'b0, 2600);

        // Stuck high: error after 60 synchronized cycles (+2 sync latency).
        exp_err++;
        err_at = 0;
        din = 1'b1;
        for (int n = 1; n <= 100; n++) begin
          @(posedge sys_clk);
          #1;
          if (pix_if.bit_err === 1'b1 && err_at == 0) err_at = n;
        end
        check("stuck_err_cycle", err_at, 62);
        check("stuck_busy", {31'd0, pix_if.busy}, 32'd0);
        send_level(1'b0, 2600);

        // Reset in the middle of a pixel.
        rgrb = 24'hABCDEF;
        for (int i = 23; i >= 12; i--) send_bit(rgrb[i]);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check_all_zero("midrst");
        sys_rst_n = 1'b1;
        for (int i = 11; i >= 0; i--) send_bit(rgrb[i]);
        send_pixel(24'h777777);
        send_level(1'b0, 2600);
        push_pix(8'h13, 8'h57, 8'h9B, 8'd0);
        send_pixel(24'h13579B);
        push_frm(8'd1, 1'b0);
        send_level(1'b0, 2600);

        done = 1'b1;
      end
    join

    check("pix_count", pix_seen, pix_pushed);
    check("frame_count", frm_seen, frm_pushed);
    check("err_count", err_seen, exp_err);
    check("queues_empty", pix_q.size() + frm_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
